// File: rtl/ddr3_local_master_pkg.sv
// ddr3_local_master_pkg: shared FSM type, size width and FIFO entry layout for the DDR3 local master.
package ddr3_local_master_pkg;
    localparam int SIZE_W        = 3;
    localparam int MAX_BURST_DEF = 4;
    localparam int DATA_W_DEF    = 64;

    typedef enum logic [1:0] {IDLE, WCOLLECT, WREQ, RREQ} lm_state_t;

    typedef struct packed {
        logic [DATA_W_DEF/8-1:0] be;
        logic [DATA_W_DEF-1:0]   data;
    } wfifo_entry_t;

    function automatic logic [SIZE_W-1:0] coerce_size(input logic [SIZE_W-1:0] bc, input int max_burst);
        return (bc == '0 || int'(bc) > max_burst) ? SIZE_W'(1) : bc;
    endfunction
endpackage

// File: rtl/ddr3_lm_wdata_fifo.sv
// ddr3_lm_wdata_fifo: synchronous write-data FIFO with count, full, empty and free-space outputs.
// DEPTH must be a power of two so the pointers wrap naturally.
module ddr3_lm_wdata_fifo #(
    parameter int W     = 72,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [AW:0]  count,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  free
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign free    = (AW+1)'(DEPTH) - count;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
endmodule

// File: rtl/ddr3_local_master.sv
// ddr3_local_master: Avalon-MM burst slave driving the DDR3 controller local interface.
// Optional sticky protocol checking on lm_error is built when DDR3_LM_ERR_CHECK_EN is defined.
module ddr3_local_master
    import ddr3_local_master_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 64,
    parameter int MAX_BURST   = MAX_BURST_DEF,
    parameter int WFIFO_DEPTH = 16,
    parameter int MAX_RD_OUT  = 8
) (
    input  logic                phy_clk,
    input  logic                reset_phy_clk_n,
    input  logic [ADDR_W-1:0]   avs_address,
    input  logic                avs_read,
    input  logic                avs_write,
    input  logic [SIZE_W-1:0]   avs_burstcount,
    input  logic [DATA_W-1:0]   avs_writedata,
    input  logic [DATA_W/8-1:0] avs_byteenable,
    output logic                avs_waitrequest,
    output logic [DATA_W-1:0]   avs_readdata,
    output logic                avs_readdatavalid,
    input  logic                local_init_done,
    input  logic                local_ready,
    output logic [ADDR_W-1:0]   local_address,
    output logic [SIZE_W-1:0]   local_size,
    output logic                local_read_req,
    output logic                local_write_req,
    output logic                local_burstbegin,
    input  logic                local_wdata_req,
    output logic [DATA_W-1:0]   local_wdata,
    output logic [DATA_W/8-1:0] local_be,
    input  logic [DATA_W-1:0]   local_rdata,
    input  logic                local_rdata_valid,
    output logic                lm_error
);
    localparam int BE_W = DATA_W / 8;
    localparam int FW   = $clog2(WFIFO_DEPTH);
    localparam int RW   = $clog2(MAX_RD_OUT + MAX_BURST + 1);

    lm_state_t              state, state_n;
    logic [ADDR_W-1:0]      addr_q;
    logic [SIZE_W-1:0]      size_q, left_q, bc;
    logic                   first_q;
    logic [RW-1:0]          rd_out, rd_out_n;
    logic                   push, wr_ok, rd_ok, wr_acc, rd_acc;
    logic                   fifo_full, fifo_empty;
    logic [FW:0]            fifo_count, fifo_free;
    logic [BE_W+DATA_W-1:0] fifo_dout;

    assign bc    = coerce_size(avs_burstcount, MAX_BURST);
    assign wr_ok = int'(fifo_free) >= int'(bc);
    assign rd_ok = int'(rd_out) + int'(bc) <= MAX_RD_OUT;

    ddr3_lm_wdata_fifo #(.W(BE_W + DATA_W), .DEPTH(WFIFO_DEPTH)) u_fifo (
        .clk   (phy_clk),
        .rst_n (reset_phy_clk_n),
        .push  (push && !fifo_full),
        .pop   (local_wdata_req && !fifo_empty),
        .din   ({avs_byteenable, avs_writedata}),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty),
        .free  (fifo_free)
    );

    // A write burst is only accepted when the whole burst fits, so WCOLLECT never stalls.
    always_comb begin
        state_n         = state;
        avs_waitrequest = 1'b1;
        wr_acc          = 1'b0;
        rd_acc          = 1'b0;
        push            = 1'b0;
        case (state)
            IDLE: begin
                avs_waitrequest = !reset_phy_clk_n || !local_init_done ||
                                  (avs_write ? !wr_ok : avs_read && !rd_ok);
                wr_acc  = avs_write && !avs_waitrequest;
                rd_acc  = avs_read && !avs_write && !avs_waitrequest;
                push    = wr_acc;
                state_n = wr_acc ? (bc == SIZE_W'(1) ? WREQ : WCOLLECT) : rd_acc ? RREQ : IDLE;
            end
            WCOLLECT: begin
                avs_waitrequest = !avs_write;
                push            = avs_write;
                state_n         = (avs_write && left_q == SIZE_W'(1)) ? WREQ : WCOLLECT;
            end
            default: state_n = local_ready ? IDLE : state;
        endcase
    end

    assign rd_out_n = rd_out + (rd_acc ? RW'(bc) : RW'(0)) - RW'(local_rdata_valid && rd_out != '0);

    assign local_write_req  = state == WREQ;
    assign local_read_req   = state == RREQ;
    assign local_burstbegin = (local_write_req || local_read_req) && first_q;
    assign local_address    = addr_q;
    assign local_size       = size_q;

    always_ff @(posedge phy_clk or negedge reset_phy_clk_n)
        if (!reset_phy_clk_n) begin
            state             <= IDLE;
            first_q           <= 1'b0;
            addr_q            <= '0;
            size_q            <= '0;
            left_q            <= '0;
            rd_out            <= '0;
            local_wdata       <= '0;
            local_be          <= '0;
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
        end else begin
            state   <= state_n;
            first_q <= state_n != state && (state_n == WREQ || state_n == RREQ);
            if (wr_acc || rd_acc) begin
                addr_q <= avs_address;
                size_q <= bc;
            end
            left_q <= wr_acc ? bc - SIZE_W'(1) : push ? left_q - SIZE_W'(1) : left_q;
            rd_out <= rd_out_n;
            if (local_wdata_req && !fifo_empty) {local_be, local_wdata} <= fifo_dout;
            avs_readdatavalid <= local_rdata_valid;
            if (local_rdata_valid) avs_readdata <= local_rdata;
        end

`ifdef DDR3_LM_ERR_CHECK_EN
    always_ff @(posedge phy_clk or negedge reset_phy_clk_n)
        if (!reset_phy_clk_n)
            lm_error <= 1'b0;
        else if ((local_wdata_req && fifo_count == '0) ||
                 (local_rdata_valid && rd_out == '0) ||
                 (push && fifo_full))
            lm_error <= 1'b1;
`else
    logic unused_count;
    assign unused_count = ^fifo_count;
    assign lm_error     = 1'b0;
`endif
endmodule
